// File: rtl/nanorv32_tcm_arbiter.sv
// Single-port TCM arbiter for the nanorv32 core: IF, D and loader ports share one SRAM.
// Loader wins outright; an IF starvation counter forces IF ahead of D after MAX_WAIT losses.
module nanorv32_tcm_arbiter #(
   parameter int unsigned ADDR_W   = 13,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [31:0]       if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [3:0]        d_be,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [31:0]       d_rdata,
   input  logic              ld_req,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [31:0]       ld_wdata,
   output logic              ld_gnt,
   output logic              ram_cs,
   output logic [3:0]        ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata,
   output logic [3:0]        if_wait_cnt
);

   localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_IF   = 2'd1;
   localparam logic [1:0] OWN_D    = 2'd2;

   logic [1:0]        owner_q, owner_d;
   logic [3:0]        wait_cnt_q, wait_cnt_d;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic              if_forced;

   always_comb begin
      if_forced = if_req && (wait_cnt_q == MAX_WAIT_C);
      ld_gnt    = !rst && ld_req;
      if_gnt    = !rst && !ld_req && if_req && (if_forced || !d_req);
      d_gnt     = !rst && !ld_req && d_req && !if_forced;
   end

   // Idle cycles replay the last address/data so the SRAM inputs do not toggle.
   always_comb begin
      ram_cs    = 1'b0;
      ram_we    = '0;
      ram_addr  = addr_q;
      ram_wdata = wdata_q;
      if (ld_gnt) begin
         ram_cs    = 1'b1;
         ram_we    = '1;
         ram_addr  = ld_addr;
         ram_wdata = ld_wdata;
      end else if (d_gnt) begin
         ram_cs   = 1'b1;
         ram_addr = d_addr;
         if (d_we) begin
            ram_we    = d_be;
            ram_wdata = d_wdata;
         end
      end else if (if_gnt) begin
         ram_cs   = 1'b1;
         ram_addr = if_addr;
      end
   end

   always_comb begin
      owner_d = OWN_NONE;
      if (if_gnt) begin
         owner_d = OWN_IF;
      end else if (d_gnt && !d_we) begin
         owner_d = OWN_D;
      end

      wait_cnt_d = wait_cnt_q;
      if (!if_req || if_gnt) begin
         wait_cnt_d = '0;
      end else if (d_gnt && (wait_cnt_q < MAX_WAIT_C)) begin
         wait_cnt_d = wait_cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_q    <= OWN_NONE;
         wait_cnt_q <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
      end else begin
         owner_q    <= owner_d;
         wait_cnt_q <= wait_cnt_d;
         addr_q     <= ram_addr;
         wdata_q    <= ram_wdata;
      end
   end

   assign if_rvalid   = (owner_q == OWN_IF);
   assign d_rvalid    = (owner_q == OWN_D);
   assign if_rdata    = ram_rdata;
   assign d_rdata     = ram_rdata;
   assign if_wait_cnt = wait_cnt_q;

endmodule

// File: tb/tb_nanorv32_tcm_arbiter.sv
// Directed bench for nanorv32_tcm_arbiter with a behavioural byte-enabled SRAM.
module tb_nanorv32_tcm_arbiter;

   localparam int unsigned ADDR_W = 13;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              if_req = 1'b0;
   logic [ADDR_W-1:0] if_addr = '0;
   logic              if_gnt, if_rvalid;
   logic [31:0]       if_rdata;
   logic              d_req = 1'b0, d_we = 1'b0;
   logic [3:0]        d_be = '0;
   logic [ADDR_W-1:0] d_addr = '0;
   logic [31:0]       d_wdata = '0;
   logic              d_gnt, d_rvalid;
   logic [31:0]       d_rdata;
   logic              ld_req = 1'b0;
   logic [ADDR_W-1:0] ld_addr = '0;
   logic [31:0]       ld_wdata = '0;
   logic              ld_gnt;
   logic              ram_cs;
   logic [3:0]        ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [31:0]       ram_wdata;
   logic [31:0]       ram_rdata = '0;
   logic [3:0]        if_wait_cnt;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   // Preload port lets the bench seed memory without a second driver on mem.
   logic              pre_en = 1'b0;
   logic [ADDR_W-1:0] pre_addr = '0;
   logic [31:0]       pre_data = '0;
   logic [31:0]       mem [0:(1<<ADDR_W)-1];

   always #5 clk = ~clk;

   nanorv32_tcm_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(4)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
      .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .if_wait_cnt(if_wait_cnt)
   );

   always @(posedge clk) begin
      if (pre_en) begin
         mem[pre_addr] <= pre_data;
      end else if (ram_cs) begin
         if (ram_we == 4'h0) begin
            ram_rdata <= mem[ram_addr];
         end else begin
            for (int b = 0; b < 4; b++) begin
               if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] v);
      @(negedge clk);
      pre_en = 1'b1; pre_addr = a; pre_data = v;
      @(negedge clk);
      pre_en = 1'b0;
   endtask

   task automatic chk_mutex(input string tag);
      int unsigned s;
      s = 32'(if_gnt) + 32'(d_gnt) + 32'(ld_gnt);
      chk(tag, 32'(s <= 1), 32'd1);
   endtask

   initial begin
      // Reset state, gnts suppressed even with requests pending
      if_req = 1'b1; d_req = 1'b1; ld_req = 1'b1;
      #2;
      chk("rst_if_gnt", 32'(if_gnt), 32'd0);
      chk("rst_d_gnt", 32'(d_gnt), 32'd0);
      chk("rst_ld_gnt", 32'(ld_gnt), 32'd0);
      chk("rst_ram_cs", 32'(ram_cs), 32'd0);
      chk("rst_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
      chk("rst_wait", 32'(if_wait_cnt), 32'd0);
      if_req = 1'b0; d_req = 1'b0; ld_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      preload(13'h010, 32'h0000_0013);
      preload(13'h020, 32'h0000_0000);
      preload(13'h001, 32'h0000_0011);
      preload(13'h002, 32'h0000_0022);

      // 1: single IF read
      @(negedge clk);
      if_req = 1'b1; if_addr = 13'h010;
      #1;
      chk("t1_if_gnt", 32'(if_gnt), 32'd1);
      chk("t1_ram_cs", 32'(ram_cs), 32'd1);
      chk("t1_ram_we", 32'(ram_we), 32'd0);
      chk("t1_ram_addr", 32'(ram_addr), 32'h010);
      @(negedge clk);
      if_req = 1'b0;
      #1;
      chk("t1_if_rvalid", 32'(if_rvalid), 32'd1);
      chk("t1_if_rdata", if_rdata, 32'h0000_0013);
      chk("t1_d_rvalid", 32'(d_rvalid), 32'd0);
      chk("t1_idle_cs", 32'(ram_cs), 32'd0);
      chk("t1_idle_addr_hold", 32'(ram_addr), 32'h010);

      // 2: D byte write then read
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b1; d_be = 4'b0010; d_addr = 13'h020; d_wdata = 32'hAABB_CCDD;
      #1;
      chk("t2_d_gnt_wr", 32'(d_gnt), 32'd1);
      chk("t2_ram_we", 32'(ram_we), 32'h2);
      chk("t2_ram_wdata", ram_wdata, 32'hAABB_CCDD);
      @(negedge clk);
      d_we = 1'b0;
      #1;
      chk("t2_d_gnt_rd", 32'(d_gnt), 32'd1);
      chk("t2_ram_we_rd", 32'(ram_we), 32'd0);
      chk("t2_no_rvalid_wr", 32'(d_rvalid), 32'd0);
      @(negedge clk);
      d_req = 1'b0;
      #1;
      chk("t2_d_rvalid", 32'(d_rvalid), 32'd1);
      chk("t2_d_rdata", d_rdata, 32'h0000_CC00);
      chk("t2_if_rvalid", 32'(if_rvalid), 32'd0);

      // 3: starvation pattern D,D,D,D,IF; stop with count at 4
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         if (k == 0) begin
            if_req = 1'b1; if_addr = 13'h006;
            d_req = 1'b1; d_we = 1'b0; d_addr = 13'h005;
         end
         #1;
         chk($sformatf("t3_cnt_%0d", k), 32'(if_wait_cnt), 32'(k % 5));
         chk($sformatf("t3_if_gnt_%0d", k), 32'(if_gnt), 32'((k % 5) == 4));
         chk($sformatf("t3_d_gnt_%0d", k), 32'(d_gnt), 32'((k % 5) != 4));
         chk_mutex($sformatf("t3_mutex_%0d", k));
      end

      // 4: loader beats a forced IF, then IF reads back loader data
      @(negedge clk);
      ld_req = 1'b1; ld_addr = 13'h040; ld_wdata = 32'hCAFF_E000;
      #1;
      chk("t4_cnt_pre", 32'(if_wait_cnt), 32'd4);
      chk("t4_ld_gnt", 32'(ld_gnt), 32'd1);
      chk("t4_if_gnt", 32'(if_gnt), 32'd0);
      chk("t4_d_gnt", 32'(d_gnt), 32'd0);
      chk("t4_ram_we", 32'(ram_we), 32'hF);
      chk("t4_ram_addr", 32'(ram_addr), 32'h040);
      chk("t4_ram_wdata", ram_wdata, 32'hCAFF_E000);
      @(negedge clk);
      ld_req = 1'b0; if_addr = 13'h040;
      #1;
      chk("t4_cnt_held", 32'(if_wait_cnt), 32'd4);
      chk("t4_if_gnt_after", 32'(if_gnt), 32'd1);
      chk("t4_d_gnt_after", 32'(d_gnt), 32'd0);
      @(negedge clk);
      if_req = 1'b0; d_req = 1'b0;
      #1;
      chk("t4_if_rvalid", 32'(if_rvalid), 32'd1);
      chk("t4_if_rdata", if_rdata, 32'hCAFF_E000);
      chk("t4_d_rvalid", 32'(d_rvalid), 32'd0);
      chk("t4_cnt_clr", 32'(if_wait_cnt), 32'd0);

      // 5: alternating IF(1)/D(2) reads every cycle
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         if_req = (k < 6) && (k % 2 == 0); if_addr = 13'h001;
         d_req  = (k < 6) && (k % 2 == 1); d_we = 1'b0; d_addr = 13'h002;
         #1;
         if (k < 6) chk($sformatf("t5_gnt_%0d", k), {30'd0, if_gnt, d_gnt}, (k % 2 == 0) ? 32'd2 : 32'd1);
         if (k > 0) begin
            chk($sformatf("t5_rv_%0d", k), {30'd0, if_rvalid, d_rvalid}, (k % 2 == 1) ? 32'd2 : 32'd1);
            chk($sformatf("t5_data_%0d", k), ram_rdata, (k % 2 == 1) ? 32'h11 : 32'h22);
         end
      end

      // 6: reset one cycle after an IF grant drops the pending rvalid
      @(negedge clk);
      if_req = 1'b1; if_addr = 13'h010;
      #1;
      chk("t6_if_gnt", 32'(if_gnt), 32'd1);
      @(negedge clk);
      #1;
      chk("t6_rvalid_pre", 32'(if_rvalid), 32'd1);
      rst = 1'b1;
      #1;
      chk("t6_rvalid_drop", 32'(if_rvalid), 32'd0);
      chk("t6_cnt", 32'(if_wait_cnt), 32'd0);
      chk("t6_gnt_in_rst", 32'(if_gnt), 32'd0);
      chk("t6_cs_in_rst", 32'(ram_cs), 32'd0);
      @(negedge clk);
      rst = 1'b0; if_req = 1'b0;
      #1;
      chk("t6_cs_idle", 32'(ram_cs), 32'd0);
      @(negedge clk);
      #1;
      chk("t6_no_late_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/nanorv32_tcm_arbiter.md
Name: nanorv32_tcm_arbiter

Overview:
- Shares the single-port TCM SRAM between three requesters: CPU instruction fetch (IF), CPU data port (D) and the program loader / debug write port (LD).
- Sits between the nanorv32 core and the TCM RAM inside the chip top.
- Grants at most one access per cycle. Routes 1-cycle-latency read data back to the requester that issued the read.
- Prevents IF starvation under continuous D traffic.

Parameters:
- ADDR_W, 13, word-address width of the TCM (32-bit words).
- MAX_WAIT, 4, consecutive cycles IF may be denied while D wins before IF is forced to win; range 1..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- if_req  input  1  IF read request.
- if_addr  input  ADDR_W  IF word address.
- if_gnt  output  1  IF request accepted this cycle (combinational).
- if_rvalid  output  1  if_rdata valid (registered).
- if_rdata  output  32  IF read data.
- d_req  input  1  D request.
- d_we  input  1  1 = write, 0 = read.
- d_be  input  4  D byte enables; used only when writing.
- d_addr  input  ADDR_W  D word address.
- d_wdata  input  32  D write data.
- d_gnt  output  1  D request accepted this cycle (combinational).
- d_rvalid  output  1  d_rdata valid (registered).
- d_rdata  output  32  D read data.
- ld_req  input  1  loader full-word write request.
- ld_addr  input  ADDR_W  loader word address.
- ld_wdata  input  32  loader write data.
- ld_gnt  output  1  loader write accepted (combinational).
- ram_cs  output  1  SRAM chip select.
- ram_we  output  4  SRAM byte write enables.
- ram_addr  output  ADDR_W  SRAM word address.
- ram_wdata  output  32  SRAM write data.
- ram_rdata  input  32  SRAM read data, valid the cycle after a read with ram_cs=1, ram_we=0.
- if_wait_cnt  output  4  current IF starvation count (debug/observability).

Behaviour:
- **Handshake**
  - A requester holds req and its address/data stable until it sees gnt high in the same cycle.
  - Each gnt accepts exactly one access.
  - Each gnt is a function of the current-cycle req inputs and the registered state only.
- **Priority, evaluated each cycle**
  1. ld_req.
  2. if_req when if_wait_cnt == MAX_WAIT.
  3. d_req.
  4. if_req.
- **Mutual exclusion:** at most one of if_gnt, d_gnt, ld_gnt is high in any cycle.
- **SRAM drive**
  - No grant: ram_cs=0, ram_we=0. ram_addr and ram_wdata are don't-care, but hold the last values to reduce toggling.
  - LD grant: ram_cs=1, ram_we=4'hF, ram_addr/ram_wdata taken from LD.
  - D write grant: ram_cs=1, ram_we=d_be, ram_addr/ram_wdata taken from D. d_be=0 is still granted; the SRAM performs no write.
  - D read or IF grant: ram_cs=1, ram_we=0, ram_addr from the winning requester.
- **Read return (owner register rd_owner ∈ {NONE, IF, D})**
  - On a clock edge, rd_owner becomes IF if this cycle granted an IF read, D if it granted a D read, otherwise NONE.
  - if_rvalid = (rd_owner==IF). d_rvalid = (rd_owner==D).
  - if_rdata and d_rdata both mirror ram_rdata combinationally; they are valid only while the corresponding rvalid is high.
  - Read latency from gnt to rvalid is exactly 1 cycle.
  - Back-to-back reads are allowed every cycle, so throughput is 1 access per cycle.
- **Starvation counter (if_wait_cnt)**
  - Incremented, saturating at MAX_WAIT, on each edge where if_req=1 and if_gnt=0 and d_gnt=1.
  - Cleared on if_gnt.
  - Cleared when if_req=0.
  - Holds its value when IF loses to LD.
  - LD always wins, even if if_wait_cnt==MAX_WAIT.
- **Reset (rst=1, asynchronous)**
  - rd_owner=NONE, if_wait_cnt=0.
  - Hence if_rvalid=0 and d_rvalid=0 immediately.
  - ram_cs and all gnt outputs are forced to 0 while rst=1.
- **Reset mid-read**
  - The pending rvalid is dropped; no late data is delivered.
  - Requesters re-issue their requests after reset deasserts.
- **Address wrap:** no address checking is performed; addresses are used modulo 2^ADDR_W.

Test Plan:
1. **Single IF read:** rst released, RAM[0x10]=0x00000013, if_req=1 with if_addr=0x10 for 1 cycle → if_gnt=1 that cycle; next cycle if_rvalid=1 and if_rdata=0x00000013; d_rvalid=0.
2. **D byte write then read:** D writes d_addr=0x20, d_be=4'b0010, d_wdata=0xAABBCCDD over RAM=0 → ram_we=4'b0010. A subsequent D read of 0x20 returns 0x0000CC00 with d_rvalid one cycle after d_gnt.
3. **Starvation:** MAX_WAIT=4, d_req and if_req held high continuously → grant sequence D,D,D,D,IF repeating. if_wait_cnt runs 0,1,2,3,4 and returns to 0 on the IF grant. No cycle has two gnts.
4. **Loader priority:**
   - ld_req, d_req and if_req all high, with if_wait_cnt=4 → ld_gnt=1, ram_we=4'hF, if_wait_cnt stays 4.
   - ld_req then dropped → IF is granted next.
   - Writing 0xCAFFE000 to 0x40 then IF-reading 0x40 returns 0xCAFFE000.
5. **Back-to-back routing:** alternate IF read of 0x1 and D read of 0x2 every cycle, with RAM[1]=0x11 and RAM[2]=0x22 → rvalid alternates IF/D with the matching data and no misrouting.
6. **Reset mid-operation:** assert rst in the cycle after an IF read gnt → if_rvalid falls immediately and if_wait_cnt=0. After rst deasserts, with no request, ram_cs=0.
